// File: rtl/parity_frame_checker.sv
// Receive-side checker for a framed serial stream: start bit, DATA_W data bits LSB first,
// one parity bit, one stop bit. Presents the word with parity and framing error flags.
module parity_frame_checker #(
    parameter int unsigned DATA_W = 8,
    parameter bit          ODD    = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_en,
    input  logic              sin,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int unsigned CntW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              acc_q, acc_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              perr_q, perr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              valid_q, valid_d;
    logic              parity_err_q, parity_err_d;
    logic              frame_err_q, frame_err_d;
    logic              busy_q, busy_d;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; every transition is qualified by the bit strobe
    always_comb begin
        state_d = state_q;
        if (in_en) begin
            unique case (state_q)
                StIdle:   if (!sin) state_d = StData;
                StData:   if (cnt_q == CntW'(DATA_W - 1)) state_d = StParity;
                StParity: state_d = StStop;
                StStop:   state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    // Datapath and registered-output next values
    always_comb begin
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        shift_d      = shift_q;
        perr_d       = perr_q;
        dout_d       = dout_q;
        valid_d      = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        if (in_en) begin
            unique case (state_q)
                StIdle: begin
                    if (!sin) begin
                        cnt_d = '0;
                        acc_d = 1'b0;
                    end
                end
                StData: begin
                    // LSB-first: the first data bit ends up in bit 0 after DATA_W shifts
                    shift_d = (shift_q >> 1) | (DATA_W'(sin) << (DATA_W - 1));
                    acc_d   = acc_q ^ sin;
                    cnt_d   = cnt_q + CntW'(1);
                end
                StParity: perr_d = acc_q ^ sin ^ ODD;
                StStop: begin
                    dout_d       = shift_q;
                    parity_err_d = perr_q;
                    frame_err_d  = ~sin;
                    valid_d      = 1'b1;
                end
                default: ;
            endcase
        end
        // Stays high through the dout_valid cycle even though the FSM is back in idle
        busy_d = (state_d != StIdle) || valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            acc_q        <= 1'b0;
            shift_q      <= '0;
            perr_q       <= 1'b0;
            dout_q       <= '0;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            shift_q      <= shift_d;
            perr_q       <= perr_d;
            dout_q       <= dout_d;
            valid_q      <= valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_parity_frame_checker.sv
// Bench for parity_frame_checker: even and odd instances share one stimulus stream and are
// checked every cycle against a frame-level model of the expected word and flags.
module tb_parity_frame_checker;

    logic       clk = 1'b0;
    logic       rst, in_en, sin;
    logic [7:0] dout0, dout1;
    logic       v0, v1, pe0, pe1, fe0, fe1, b0, b1;

    always #5 clk = ~clk;

    parity_frame_checker #(.DATA_W(8), .ODD(1'b0)) u_even (
        .clk(clk), .rst(rst), .in_en(in_en), .sin(sin), .dout(dout0), .dout_valid(v0),
        .parity_err(pe0), .frame_err(fe0), .busy(b0)
    );

    parity_frame_checker #(.DATA_W(8), .ODD(1'b1)) u_odd (
        .clk(clk), .rst(rst), .in_en(in_en), .sin(sin), .dout(dout1), .dout_valid(v1),
        .parity_err(pe1), .frame_err(fe1), .busy(b1)
    );

    int errors = 0;
    int checks = 0;

    // Expectation armed by the stop-bit strobe, consumed in the following cycle
    bit         pending = 1'b0;
    logic [7:0] exp_dout;
    bit         exp_pe0, exp_pe1, exp_fe;
    // Values the outputs must hold between pulses
    logic [7:0] hold_dout = 8'h00;
    bit         hold_pe0 = 1'b0, hold_pe1 = 1'b0, hold_fe = 1'b0;

    typedef struct {
        logic [7:0] data;
        bit         par;
        bit         stop;
        int         gap;
        bit         exp_pe_even;
        bit         exp_fe;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Runs at every negedge before inputs change
    task automatic tick_check();
        chk("valid_even", {31'd0, v0}, {31'd0, pending});
        chk("valid_odd", {31'd0, v1}, {31'd0, pending});
        if (pending) begin
            hold_dout = exp_dout;
            hold_pe0  = exp_pe0;
            hold_pe1  = exp_pe1;
            hold_fe   = exp_fe;
            chk("busy_at_valid", {30'd0, b0, b1}, 32'd3);
        end
        chk("dout_even", {24'd0, dout0}, {24'd0, hold_dout});
        chk("dout_odd", {24'd0, dout1}, {24'd0, hold_dout});
        chk("perr_even", {31'd0, pe0}, {31'd0, hold_pe0});
        chk("perr_odd", {31'd0, pe1}, {31'd0, hold_pe1});
        chk("ferr", {30'd0, fe0, fe1}, {30'd0, hold_fe, hold_fe});
        pending = 1'b0;
    endtask

    task automatic drive(input bit en, input bit b);
        @(negedge clk);
        tick_check();
        in_en = en;
        sin   = b;
    endtask

    task automatic send_frame(input logic [7:0] data, input bit par, input bit stop,
                              input int gap, input bit pe_even, input bit fe);
        logic [10:0] bits;
        bits = {stop, par, data, 1'b0};
        for (int i = 0; i < 11; i++) begin
            for (int g = 0; g < gap; g++) drive(1'b0, 1'($urandom));
            drive(1'b1, bits[i]);
        end
        pending  = 1'b1;
        exp_dout = data;
        exp_pe0  = pe_even;
        exp_pe1  = ~pe_even;
        exp_fe   = fe;
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 0, 1'b0, 1'b0};
        vecs[1] = '{8'hA5, 1'b1, 1'b1, 0, 1'b1, 1'b0};
        vecs[2] = '{8'h01, 1'b1, 1'b1, 0, 1'b0, 1'b0};
        vecs[3] = '{8'h3C, 1'b0, 1'b0, 0, 1'b0, 1'b1};
        vecs[4] = '{8'hFF, 1'b0, 1'b1, 0, 1'b0, 1'b0};
        vecs[5] = '{8'h5A, 1'b0, 1'b1, 2, 1'b0, 1'b0};
        vecs[6] = '{8'h07, 1'b0, 1'b1, 0, 1'b1, 1'b0};
        vecs[7] = '{8'h07, 1'b1, 1'b1, 0, 1'b0, 1'b0};

        rst   = 1'b1;
        in_en = 1'b0;
        sin   = 1'b1;
        repeat (3) @(negedge clk);
        @(negedge clk);
        chk("reset_busy", {30'd0, b0, b1}, 32'd0);
        rst = 1'b0;
        drive(1'b1, 1'b1);

        // Directed frames, all back-to-back unless a gap is given
        foreach (vecs[i])
            send_frame(vecs[i].data, vecs[i].par, vecs[i].stop, vecs[i].gap,
                       vecs[i].exp_pe_even, vecs[i].exp_fe);
        drive(1'b0, 1'b1);

        // Abort a frame with reset after the 4th data bit
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b1);
        chk("busy_mid_frame", {30'd0, b0, b1}, 32'd3);
        rst       = 1'b1;
        hold_dout = 8'h00;
        hold_pe0  = 1'b0;
        hold_pe1  = 1'b0;
        hold_fe   = 1'b0;
        drive(1'b0, 1'b1);
        chk("busy_after_rst", {30'd0, b0, b1}, 32'd0);
        rst = 1'b0;
        send_frame(8'h81, 1'b0, 1'b1, 0, 1'b0, 1'b0);

        // Idle line: no pulses, not busy
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1);
            if (i > 0) chk("idle_busy", {30'd0, b0, b1}, 32'd0);
        end

        // Random frames against the parity rule
        for (int n = 0; n < 40; n++) begin
            logic [7:0] d;
            bit         p, s;
            d = 8'($urandom);
            p = 1'($urandom);
            s = ($urandom_range(0, 3) != 0);
            send_frame(d, p, s, $urandom_range(0, 2), (^d) ^ p, ~s);
            if ($urandom_range(0, 2) == 0) begin
                for (int k = 0; k < int'($urandom_range(1, 4)); k++) drive(1'b1, 1'b1);
            end
        end
        repeat (4) drive(1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
